encoder_velocity: RTL and testbench



---
 rtl/enc_pkg.sv | 21 ++
 rtl/enc_movavg.sv | 79 +++++++
 rtl/encoder_velocity.sv | 113 +++++++++++
 tb/tb_encoder_velocity.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the encoder velocity block.
// Holds the measurement state encoding and the modular delta helper.
package enc_pkg;

    localparam int ENC_W              = 32;
    localparam int DEFAULT_SAMPLE_DIV = 500000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        FILL  = 2'd2,
        RUN   = 2'd3
    } enc_state_t;

    // Modular difference; read as signed so a count wrap gives a small step.
    function automatic logic [ENC_W-1:0] enc_delta(input logic [ENC_W-1:0] cur,
                                                   input logic [ENC_W-1:0] prev);
        return cur - prev;
    endfunction

endpackage

// File: rtl/enc_movavg.sv
// Ring buffer of the last N deltas with a running sum; average = floor(sum / N).
// Push in cycle T -> o_avg/o_avg_vld/o_full registered at T+1; i_clear beats i_push.
module enc_movavg
    import enc_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_push,
    input  logic                    i_clear,
    input  logic signed [ENC_W-1:0] i_delta,
    output logic signed [ENC_W-1:0] o_avg,
    output logic                    o_avg_vld,
    output logic                    o_full
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = ENC_W + AVG_LOG2;
    localparam int PW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    logic signed [ENC_W-1:0] r_buf [N];
    logic        [PW-1:0]    r_wr_ptr;
    logic        [CW-1:0]    r_fill;
    logic signed [SW-1:0]    r_sum;
    logic signed [ENC_W-1:0] r_avg;
    logic                    r_avg_vld;
    logic                    r_full;

    logic signed [ENC_W-1:0] w_oldest;
    logic signed [SW-1:0]    w_sum_nxt;
    logic signed [SW-1:0]    w_shift;
    logic                    w_last_fill;

    // The slot under the write pointer holds the oldest delta once the window is full.
    assign w_oldest    = r_full ? r_buf[r_wr_ptr] : '0;
    assign w_sum_nxt   = r_sum + SW'(i_delta) - SW'(w_oldest);
    assign w_shift     = w_sum_nxt >>> AVG_LOG2;
    assign w_last_fill = (r_fill == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_sum     <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            r_avg_vld <= 1'b0;
            if (i_clear) begin
                for (int i = 0; i < N; i++) r_buf[i] <= '0;
                r_wr_ptr <= '0;
                r_fill   <= '0;
                r_sum    <= '0;
                r_full   <= 1'b0;
            end else if (i_push) begin
                r_buf[r_wr_ptr] <= i_delta;
                r_wr_ptr        <= (r_wr_ptr == PW'(N - 1)) ? '0 : r_wr_ptr + 1'b1;
                r_sum           <= w_sum_nxt;
                if (!r_full)
                    r_fill <= r_fill + 1'b1;
                if (w_last_fill)
                    r_full <= 1'b1;
                if (r_full || w_last_fill) begin
                    r_avg     <= w_shift[ENC_W-1:0];
                    r_avg_vld <= 1'b1;
                end
            end
        end
    end

    assign o_avg     = r_avg;
    assign o_avg_vld = r_avg_vld;
    assign o_full    = r_full;

endmodule

// File: rtl/encoder_velocity.sv
// Samples the encoder count every SAMPLE_DIV cycles, emits delta and moving-average velocity.
// Tick at T -> delta at T+1 -> velocity/velocityValid at T+2; counter writes drop the window.
module encoder_velocity
    import enc_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int AVG_LOG2   = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [ENC_W-1:0] encoderValue,
    input  logic             encoderWrite,
    output logic [ENC_W-1:0] delta,
    output logic [ENC_W-1:0] velocity,
    output logic             velocityValid,
    output logic             windowFull
);

    localparam int TW = $clog2(SAMPLE_DIV);

    enc_state_t              r_state;
    enc_state_t              w_state_nxt;
    logic        [TW-1:0]    r_tick_cnt;
    logic        [ENC_W-1:0] r_prev;
    logic signed [ENC_W-1:0] r_delta;
    logic                    r_push;

    logic                    w_tick;
    logic                    w_accept;
    logic                    w_prime;
    logic                    w_sample;
    logic                    w_clear;
    logic signed [ENC_W-1:0] w_avg;
    logic                    w_avg_vld;
    logic                    w_full;

    assign w_tick = enable && (r_tick_cnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!resetn)
            r_tick_cnt <= '0;
        else if (!enable || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // A counter write in the tick cycle makes that sample meaningless, so it is never accepted.
    assign w_accept = w_tick && !encoderWrite;
    assign w_prime  = w_accept && (r_state == PRIME);
    assign w_sample = w_accept && ((r_state == FILL) || (r_state == RUN));
    assign w_clear  = !enable || encoderWrite;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else if (encoderWrite) begin
            w_state_nxt = PRIME;
        end else begin
            unique case (r_state)
                IDLE:    w_state_nxt = PRIME;
                PRIME:   if (w_tick) w_state_nxt = FILL;
                FILL:    if (w_full) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prev  <= '0;
            r_delta <= '0;
            r_push  <= 1'b0;
        end else begin
            r_push <= w_sample;
            if (w_prime)
                r_prev <= encoderValue;
            if (w_sample) begin
                r_delta <= enc_delta(encoderValue, r_prev);
                r_prev  <= encoderValue;
            end
        end
    end

    enc_movavg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_movavg (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (r_push),
        .i_clear   (w_clear),
        .i_delta   (r_delta),
        .o_avg     (w_avg),
        .o_avg_vld (w_avg_vld),
        .o_full    (w_full)
    );

    assign delta         = r_delta;
    assign velocity      = w_avg;
    assign velocityValid = w_avg_vld;
    assign windowFull    = w_full;

endmodule

// File: tb/tb_encoder_velocity.sv
// Directed bench: one table record per 10-cycle sample period, plus enable-drop and reset corners.
module tb_encoder_velocity;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [31:0] encoderValue;
    logic        encoderWrite;
    logic [31:0] delta;
    logic [31:0] velocity;
    logic        velocityValid;
    logic        windowFull;

    int n_vec = 0;
    int n_bad = 0;

    encoder_velocity #(
        .SAMPLE_DIV (10),
        .AVG_LOG2   (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .encoderValue  (encoderValue),
        .encoderWrite  (encoderWrite),
        .delta         (delta),
        .velocity      (velocity),
        .velocityValid (velocityValid),
        .windowFull    (windowFull)
    );

    always #5 clk = ~clk;

    // val is held for the whole period; wr asserts encoderWrite in the tick cycle.
    // Expected fields describe what is observed during that period.
    typedef struct {
        logic [31:0] val;
        bit          wr;
        int          vld;
        logic [31:0] vel;
        logic [31:0] dlt;
        bit          full;
    } vec_t;

    vec_t tab1 [24];
    vec_t tab2 [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int vcnt;
        int vk;
        vcnt = 0;
        vk   = -1;
        encoderValue = v.val;
        for (int k = 0; k < 10; k++) begin
            encoderWrite = (v.wr && k == 9);
            if (velocityValid) begin
                vcnt++;
                vk = k;
            end
            if (k == 9) begin
                check({tag, ".vel"},   velocity,   v.vel);
                check({tag, ".delta"}, delta,      v.dlt);
                check({tag, ".full"},  {31'd0, windowFull}, {31'd0, v.full});
            end
            step();
        end
        encoderWrite = 1'b0;
        check({tag, ".vld_cnt"}, vcnt, v.vld);
        if (vcnt > 0)
            check({tag, ".vld_pos"}, vk, 1);
    endtask

    initial begin
        int pulses;

        // Constant +3 motion straddling the 32-bit wrap, reverse/floor, then preload in RUN.
        tab1[0]  = '{32'hFFFF_FFF5, 1'b0, 0, 32'h0,         32'h0,         1'b0};
        tab1[1]  = '{32'hFFFF_FFF8, 1'b0, 0, 32'h0,         32'h0,         1'b0};
        tab1[2]  = '{32'hFFFF_FFFB, 1'b0, 0, 32'h0,         32'd3,         1'b0};
        tab1[3]  = '{32'hFFFF_FFFE, 1'b0, 0, 32'h0,         32'd3,         1'b0};
        tab1[4]  = '{32'h0000_0001, 1'b0, 0, 32'h0,         32'd3,         1'b0};
        tab1[5]  = '{32'h0000_0004, 1'b0, 1, 32'd3,         32'd3,         1'b1};
        tab1[6]  = '{32'h0000_0007, 1'b0, 1, 32'd3,         32'd3,         1'b1};
        tab1[7]  = '{32'h0000_000A, 1'b0, 1, 32'd3,         32'd3,         1'b1};
        tab1[8]  = '{32'h0000_0009, 1'b0, 1, 32'd3,         32'd3,         1'b1};
        tab1[9]  = '{32'h0000_0007, 1'b0, 1, 32'd2,         32'hFFFF_FFFF, 1'b1};
        tab1[10] = '{32'h0000_0005, 1'b0, 1, 32'd0,         32'hFFFF_FFFE, 1'b1};
        tab1[11] = '{32'h0000_0003, 1'b0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        tab1[12] = '{32'h0000_0004, 1'b0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1};
        tab1[13] = '{32'h0000_0006, 1'b0, 1, 32'hFFFF_FFFE, 32'd1,         1'b1};
        tab1[14] = '{32'h0000_0008, 1'b0, 1, 32'hFFFF_FFFF, 32'd2,         1'b1};
        tab1[15] = '{32'h0000_000A, 1'b0, 1, 32'd0,         32'd2,         1'b1};
        tab1[16] = '{32'h0000_000C, 1'b0, 1, 32'd1,         32'd2,         1'b1};
        tab1[17] = '{32'd50000,     1'b1, 1, 32'd2,         32'd2,         1'b1};
        tab1[18] = '{32'd50003,     1'b0, 0, 32'd2,         32'd2,         1'b0};
        tab1[19] = '{32'd50006,     1'b0, 0, 32'd2,         32'd2,         1'b0};
        tab1[20] = '{32'd50009,     1'b0, 0, 32'd2,         32'd3,         1'b0};
        tab1[21] = '{32'd50012,     1'b0, 0, 32'd2,         32'd3,         1'b0};
        tab1[22] = '{32'd50015,     1'b0, 0, 32'd2,         32'd3,         1'b0};
        tab1[23] = '{32'd50018,     1'b0, 1, 32'd3,         32'd3,         1'b1};

        // After re-enable: held outputs, re-prime, then +5 per period.
        tab2[0] = '{32'd1000, 1'b0, 0, 32'd3, 32'd3, 1'b0};
        tab2[1] = '{32'd1005, 1'b0, 0, 32'd3, 32'd3, 1'b0};
        tab2[2] = '{32'd1010, 1'b0, 0, 32'd3, 32'd5, 1'b0};
        tab2[3] = '{32'd1015, 1'b0, 0, 32'd3, 32'd5, 1'b0};
        tab2[4] = '{32'd1020, 1'b0, 0, 32'd3, 32'd5, 1'b0};
        tab2[5] = '{32'd1025, 1'b0, 1, 32'd5, 32'd5, 1'b1};
        tab2[6] = '{32'd1030, 1'b0, 1, 32'd5, 32'd5, 1'b1};

        resetn       = 1'b0;
        enable       = 1'b0;
        encoderValue = 32'h0;
        encoderWrite = 1'b0;
        repeat (3) step();
        check("rst.vel",   velocity, 32'h0);
        check("rst.delta", delta,    32'h0);
        check("rst.vld",   {31'd0, velocityValid}, 32'h0);
        check("rst.full",  {31'd0, windowFull},    32'h0);
        resetn = 1'b1;
        step();

        enable = 1'b1;
        for (int i = 0; i < 24; i++)
            run_vec(tab1[i], $sformatf("P%0d", i));

        // Enable drop mid-RUN: one pending pulse lands first, then everything idles.
        encoderValue = 32'd50021;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (velocityValid) pulses++;
            step();
        end
        check("drop.pre_pulses", pulses, 1);
        enable = 1'b0;
        step();
        check("drop.full",  {31'd0, windowFull},    32'h0);
        check("drop.vld",   {31'd0, velocityValid}, 32'h0);
        check("drop.vel",   velocity, 32'd3);
        check("drop.delta", delta,    32'd3);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (velocityValid) pulses++;
            step();
        end
        check("drop.idle_pulses", pulses, 0);

        enable = 1'b1;
        for (int i = 0; i < 7; i++)
            run_vec(tab2[i], $sformatf("Q%0d", i));

        // Now at T+1 after the last tick: reset must swallow the pending result.
        resetn = 1'b0;
        step();
        check("rstmid.vld",   {31'd0, velocityValid}, 32'h0);
        check("rstmid.vel",   velocity, 32'h0);
        check("rstmid.delta", delta,    32'h0);
        check("rstmid.full",  {31'd0, windowFull},    32'h0);
        step();
        resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (velocityValid) pulses++;
            step();
        end
        check("rstmid.after_pulses", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
